// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store FIFO feeding memctrl one access at a time, load results broadcast on the CDB.
// Issue 1 cycle after enqueue; req_ready drops when full, on misbranch or rdy=0. `LSU_MISALIGN_CHK_EN adds cdb_misalign_o.
module lsu_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rdy_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_store_i,
    input  logic [2:0]                req_funct3_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic [DATA_W-1:0]         req_data_i,
    input  logic [TAG_W-1:0]          req_tag_i,
    output logic                      mem_en_o,
    output logic                      mem_wr_o,
    output logic [2:0]                mem_size_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_done_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      misbranch_i,
    output logic                      cdb_valid_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic [DATA_W-1:0]         cdb_result_o,
`ifdef LSU_MISALIGN_CHK_EN
    output logic                      cdb_misalign_o,
`endif
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

    typedef struct packed {
        logic              store;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_e            state_q, state_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_result_q, cdb_result_d;
`ifdef LSU_MISALIGN_CHK_EN
    logic              cdb_mis_q, cdb_mis_d;
    logic              head_mis;
`endif

    logic [PW-1:0]     wr_idx, rd_idx;
    logic              full, empty, enq, pop, head_live;
    entry_t            head;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3, input logic [DATA_W-1:0] d);
        case (f3)
            3'b000:  load_ext = {{(DATA_W-8){d[7]}}, d[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){d[15]}}, d[15:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, d[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    assign wr_idx      = wr_ptr_q[PW-1:0];
    assign rd_idx      = rd_ptr_q[PW-1:0];
    assign full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign req_ready_o = rdy_i & ~misbranch_i & ~full;
    assign enq         = req_valid_i & req_ready_o;
    assign head        = ent_q[rd_idx];
    // A load squashed in the same cycle it would issue must not go out.
    assign head_live   = vld_q[rd_idx] & ~(misbranch_i & ~head.store);
`ifdef LSU_MISALIGN_CHK_EN
    assign head_mis    = ((head.funct3[1:0] == 2'b01) && head.addr[0]) ||
                         ((head.funct3[1:0] == 2'b10) && (head.addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        mem_en_d     = 1'b0;
        mem_wr_d     = mem_wr_q;
        mem_size_d   = mem_size_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cdb_valid_d  = 1'b0;
        cdb_tag_d    = cdb_tag_q;
        cdb_result_d = cdb_result_q;
`ifdef LSU_MISALIGN_CHK_EN
        cdb_mis_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (!head_live) begin
                        pop = 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
                    end else if (head_mis) begin
                        pop = 1'b1;
                        if (!head.store) begin
                            cdb_valid_d  = 1'b1;
                            cdb_tag_d    = head.tag;
                            cdb_result_d = '0;
                            cdb_mis_d    = 1'b1;
                        end
`endif
                    end else begin
                        mem_en_d    = 1'b1;
                        mem_wr_d    = head.store;
                        mem_size_d  = size_of(head.funct3);
                        mem_addr_d  = head.addr;
                        mem_wdata_d = head.data;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_done_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                    if (!head.store && !misbranch_i) begin
                        cdb_valid_d  = 1'b1;
                        cdb_tag_d    = head.tag;
                        cdb_result_d = load_ext(head.funct3, mem_rdata_i);
                    end
                end else if (misbranch_i && !head.store) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_done_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        vld_d = vld_q;
        if (misbranch_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!ent_q[i].store) vld_d[i] = 1'b0;
            end
        end
        if (pop) vld_d[rd_idx] = 1'b0;
        if (enq) vld_d[wr_idx] = 1'b1;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            vld_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_size_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_result_q <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            cdb_mis_q    <= 1'b0;
`endif
        end else if (rdy_i) begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_size_q   <= mem_size_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_result_q <= cdb_result_d;
`ifdef LSU_MISALIGN_CHK_EN
            cdb_mis_q    <= cdb_mis_d;
`endif
        end
    end

    // Payload needs no reset: it is only read behind a valid bit or non-empty FIFO.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            ent_q[wr_idx] <= '{store:  req_store_i,  funct3: req_funct3_i, addr: req_addr_i,
                               data:   req_data_i,   tag:    req_tag_i};
        end
    end

    assign mem_en_o     = mem_en_q;
    assign mem_wr_o     = mem_wr_q;
    assign mem_size_o   = mem_size_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cdb_valid_o  = cdb_valid_q;
    assign cdb_tag_o    = cdb_tag_q;
    assign cdb_result_o = cdb_result_q;
`ifdef LSU_MISALIGN_CHK_EN
    assign cdb_misalign_o = cdb_mis_q;
`endif
endmodule
